// File: rtl/decode_pkg.sv
// Shared decode types for the decode stage.
// Opcodes, FSM states and decoded-field bundle.
package decode_pkg;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    REQ_A,
    REQ_B,
    REQ_AB,
    DRAIN,
    OUT
  } state_e;

  typedef struct packed {
    logic       need_a;
    logic       need_b;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] wr_num;
    logic       wr_en;
    logic       halt;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/decode_stage_fields.sv
// Combinational field decoder for one instruction.
// Unused source registers are forced to 0.
module instr_fields
  import decode_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       instr,
  output dec_t              fld,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
);

  logic [2:0] opc;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [2:0] rm;

  assign opc = instr[15:13];
  assign op  = instr[12:11];
  assign rn  = instr[10:8];
  assign rd  = instr[7:5];
  assign rm  = instr[2:0];

  assign sximm5 = {{(DATA_W-5){instr[4]}}, instr[4:0]};
  assign sximm8 = {{(DATA_W-8){instr[7]}}, instr[7:0]};
  assign shift  = (opc == OP_MOV || opc == OP_ALU)
                ? instr[4:3] : 2'b00;

  // Operand needs and destination per opcode/op pair
  always_comb begin
    fld = '0;
    unique case (opc)
      OP_MOV: begin
        if (op == 2'b10) begin
          fld.wr_num = rn;
          fld.wr_en  = 1'b1;
        end else if (op == 2'b00) begin
          fld.need_b = 1'b1;
          fld.src_b  = rm;
          fld.wr_num = rd;
          fld.wr_en  = 1'b1;
        end else begin
          fld.illegal = 1'b1;
        end
      end
      OP_ALU: begin
        fld.need_b = 1'b1;
        fld.src_b  = rm;
        if (op != 2'b11) begin
          fld.need_a = 1'b1;
          fld.src_a  = rn;
        end
        if (op != 2'b01) begin
          fld.wr_num = rd;
          fld.wr_en  = 1'b1;
        end
      end
      OP_LDR: begin
        if (op == 2'b00) begin
          fld.need_a = 1'b1;
          fld.src_a  = rn;
          fld.wr_num = rd;
          fld.wr_en  = 1'b1;
        end else begin
          fld.illegal = 1'b1;
        end
      end
      OP_STR: begin
        if (op == 2'b00) begin
          fld.need_a = 1'b1;
          fld.src_a  = rn;
          fld.need_b = 1'b1;
          fld.src_b  = rd;
        end else begin
          fld.illegal = 1'b1;
        end
      end
      OP_HALT: fld.halt = 1'b1;
      default: fld.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes, fetches operands, emits packet.
// Packet registers load on accept and hold until taken.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int READ_PORTS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [2:0]        rf_addr_a,
  output logic [2:0]        rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        opcode,
  output logic [1:0]        aluop,
  output logic [1:0]        shift,
  output logic [2:0]        wr_num,
  output logic              wr_en,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic              halt,
  output logic              illegal
);

  state_e            state_q, state_d;
  dec_t              fld_q, fld_d, fld;
  logic [2:0]        opcode_q, opcode_d;
  logic [1:0]        aluop_q, aluop_d;
  logic [1:0]        shift_q, shift_d, f_shift;
  logic [DATA_W-1:0] sx5_q, sx5_d, f_sx5;
  logic [DATA_W-1:0] sx8_q, sx8_d, f_sx8;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              accept;

  instr_fields #(.DATA_W(DATA_W)) u_fields (
    .instr  (in_instr),
    .fld    (fld),
    .shift  (f_shift),
    .sximm5 (f_sx5),
    .sximm8 (f_sx8)
  );

  function automatic state_e first_state(dec_t f);
    if (!f.need_a && !f.need_b) return OUT;
    if (READ_PORTS == 2)        return REQ_AB;
    if (f.need_a)               return REQ_A;
    return REQ_B;
  endfunction

  assign accept = in_valid && in_ready;

  // Handshake and register-file address drive
  always_comb begin
    in_ready  = !reset && (state_q == IDLE ||
                (state_q == OUT && out_ready));
    out_valid = (state_q == OUT);
    rf_addr_a = 3'd0;
    rf_addr_b = 3'd0;
    unique case (state_q)
      REQ_A:  rf_addr_a = fld_q.src_a;
      REQ_B:  rf_addr_a = fld_q.src_b;
      REQ_AB: begin
        rf_addr_a = fld_q.src_a;
        rf_addr_b = fld_q.src_b;
      end
      default: ;
    endcase
  end

  // Next state, operand capture and packet load
  always_comb begin
    state_d  = state_q;
    fld_d    = fld_q;
    opcode_d = opcode_q;
    aluop_d  = aluop_q;
    shift_d  = shift_q;
    sx5_d    = sx5_q;
    sx8_d    = sx8_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    unique case (state_q)
      IDLE:   ;
      REQ_A:  state_d = fld_q.need_b ? REQ_B : DRAIN;
      REQ_B: begin
        if (fld_q.need_a) op_a_d = rf_data_a;
        state_d = DRAIN;
      end
      REQ_AB: state_d = DRAIN;
      DRAIN: begin
        if (READ_PORTS == 2) begin
          if (fld_q.need_a) op_a_d = rf_data_a;
          if (fld_q.need_b) op_b_d = rf_data_b;
        end else if (fld_q.need_b) begin
          op_b_d = rf_data_a;
        end else begin
          op_a_d = rf_data_a;
        end
        state_d = OUT;
      end
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d  = first_state(fld);
      fld_d    = fld;
      opcode_d = in_instr[15:13];
      aluop_d  = in_instr[12:11];
      shift_d  = f_shift;
      sx5_d    = f_sx5;
      sx8_d    = f_sx8;
      op_a_d   = '0;
      op_b_d   = '0;
    end
  end

  // State and packet registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      fld_q    <= '0;
      opcode_q <= '0;
      aluop_q  <= '0;
      shift_q  <= '0;
      sx5_q    <= '0;
      sx8_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      fld_q    <= fld_d;
      opcode_q <= opcode_d;
      aluop_q  <= aluop_d;
      shift_q  <= shift_d;
      sx5_q    <= sx5_d;
      sx8_q    <= sx8_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
    end
  end

  assign opcode  = opcode_q;
  assign aluop   = aluop_q;
  assign shift   = shift_q;
  assign wr_num  = fld_q.wr_num;
  assign wr_en   = fld_q.wr_en;
  assign halt    = fld_q.halt;
  assign illegal = fld_q.illegal;
  assign op_a    = op_a_q;
  assign op_b    = op_b_q;
  assign sximm5  = sx5_q;
  assign sximm8  = sx8_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage.
// One single-port and one dual-port instance.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_ready;
  logic [15:0] in_instr;
  logic [15:0] regs [8];

  logic        in_valid1, in_ready1, out_valid1;
  logic [2:0]  addr_a1, addr_b1, opcode1, wr_num1;
  logic [1:0]  aluop1, shift1;
  logic        wr_en1, halt1, illegal1;
  logic [15:0] data_a1, data_b1, op_a1, op_b1, sx5_1, sx8_1;

  logic        in_valid2, in_ready2, out_valid2;
  logic [2:0]  addr_a2, addr_b2, opcode2, wr_num2;
  logic [1:0]  aluop2, shift2;
  logic        wr_en2, halt2, illegal2;
  logic [15:0] data_a2, data_b2, op_a2, op_b2, sx5_2, sx8_2;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int cnt;
  logic [2:0] a_k1, a_k2, b_k1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    data_a1 <= regs[addr_a1];
    data_b1 <= regs[addr_b1];
    data_a2 <= regs[addr_a2];
    data_b2 <= regs[addr_b2];
  end

  decode_stage #(.DATA_W(16), .READ_PORTS(1)) u_rp1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_instr(in_instr),
    .rf_addr_a(addr_a1), .rf_addr_b(addr_b1),
    .rf_data_a(data_a1), .rf_data_b(data_b1),
    .out_valid(out_valid1), .out_ready(out_ready),
    .opcode(opcode1), .aluop(aluop1), .shift(shift1),
    .wr_num(wr_num1), .wr_en(wr_en1),
    .op_a(op_a1), .op_b(op_b1),
    .sximm5(sx5_1), .sximm8(sx8_1),
    .halt(halt1), .illegal(illegal1)
  );

  decode_stage #(.DATA_W(16), .READ_PORTS(2)) u_rp2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_instr(in_instr),
    .rf_addr_a(addr_a2), .rf_addr_b(addr_b2),
    .rf_data_a(data_a2), .rf_data_b(data_b2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .opcode(opcode2), .aluop(aluop2), .shift(shift2),
    .wr_num(wr_num2), .wr_en(wr_en2),
    .op_a(op_a2), .op_b(op_b2),
    .sximm5(sx5_2), .sximm8(sx8_2),
    .halt(halt2), .illegal(illegal2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic issue1(input logic [15:0] ins);
    in_instr  = ins;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat  = 1;
    a_k1 = addr_a1;
    b_k1 = addr_b1;
    a_k2 = '0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) a_k2 = addr_a1;
    end
  endtask

  task automatic issue2(input logic [15:0] ins);
    in_instr  = ins;
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat  = 1;
    a_k1 = addr_a2;
    b_k1 = addr_b2;
    while (!out_valid2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    regs[0] = 16'd9;
    regs[1] = 16'd7;
    regs[4] = 16'h0010;
    regs[5] = 16'h0022;
    reset     = 1'b1;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    out_ready = 1'b0;
    in_instr  = 16'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready1, 0);
    check("rst_out_valid", out_valid1, 0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", in_ready1, 1);
    check("idle_op_a", op_a1, 0);
    check("idle_illegal", illegal1, 0);
    check("idle_addr_a", addr_a1, 0);

    issue1(16'hA148);
    check("add_lat", lat, 4);
    check("add_addr_k1", a_k1, 1);
    check("add_addr_k2", a_k2, 0);
    check("add_addr_b", b_k1, 0);
    check("add_op_a", op_a1, 7);
    check("add_op_b", op_b1, 9);
    check("add_wr_num", wr_num1, 2);
    check("add_wr_en", wr_en1, 1);
    check("add_shift", shift1, 1);
    check("add_opcode", opcode1, 3'b101);
    drain_out();

    issue1(16'hB820);
    check("mvn_lat", lat, 3);
    check("mvn_op_a", op_a1, 0);
    check("mvn_op_b", op_b1, 9);
    check("mvn_wr_num", wr_num1, 1);
    check("mvn_aluop", aluop1, 3);
    drain_out();

    issue1(16'hD3FB);
    check("mov_lat", lat, 1);
    check("mov_addr", a_k1, 0);
    check("mov_sximm8", sx8_1, 16'hFFFB);
    check("mov_wr_num", wr_num1, 3);
    check("mov_op_a", op_a1, 0);
    check("mov_op_b", op_b1, 0);

    in_instr  = 16'hE000;
    in_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", in_ready1, 0);
      check("bp_out_valid", out_valid1, 1);
      check("bp_sximm8", sx8_1, 16'hFFFB);
      check("bp_wr_num", wr_num1, 3);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    out_ready = 1'b0;
    check("halt_valid", out_valid1, 1);
    check("halt_flag", halt1, 1);
    check("halt_wr_en", wr_en1, 0);
    check("halt_addr", addr_a1, 0);
    drain_out();

    issue1(16'h0000);
    check("ill_lat", lat, 1);
    check("ill_flag", illegal1, 1);
    check("ill_halt", halt1, 0);
    check("ill_addr", a_k1, 0);
    drain_out();

    in_instr  = 16'hA148;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_mid_in_ready", in_ready1, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_valid", out_valid1, 0);
    check("rst_mid_op_a", op_a1, 0);
    check("rst_mid_wr_num", wr_num1, 0);
    check("rst_mid_addr", addr_a1, 0);
    #1;
    check("rst_mid_ready", in_ready1, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid1) cnt++;
    end
    check("rst_mid_no_emit", cnt, 0);

    issue2(16'h84A3);
    check("str_lat", lat, 3);
    check("str_addr_a", a_k1, 4);
    check("str_addr_b", b_k1, 5);
    check("str_op_a", op_a2, 16'h0010);
    check("str_op_b", op_b2, 16'h0022);
    check("str_sximm5", sx5_2, 3);
    check("str_wr_en", wr_en2, 0);
    drain_out();

    issue2(16'hA148);
    check("add2_lat", lat, 3);
    check("add2_addr_a", a_k1, 1);
    check("add2_addr_b", b_k1, 0);
    check("add2_op_a", op_a2, 7);
    check("add2_op_b", op_b2, 9);
    check("add2_shift", shift2, 1);
    drain_out();
    check("add2_idle", out_valid2, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised successor to the combinational instruction decoder. It accepts one 16-bit instruction per handshake and decodes opcode, ALU op, shift, destination and sign-extended immediates. It then sequences its own register-file operand reads and presents one fully-formed decoded packet to the execute stage with a valid/ready handshake. It sits between fetch and execute and replaces the external nsel sequencing done by the controller.

Parameters:
DATA_W, 16, datapath and immediate sign-extension width; legal when DATA_W >= 16.
READ_PORTS, 1, register-file read ports used; 1 = fetch A then B serially, 2 = fetch A and B in the same cycle.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage accepts an instruction this cycle
in_instr  in  16  instruction word
rf_addr_a  out  3  read address, port A (the only port when READ_PORTS=1)
rf_addr_b  out  3  read address, port B (driven 0 when READ_PORTS=1)
rf_data_a  in  DATA_W  port A data, valid the cycle after the address
rf_data_b  in  DATA_W  port B data, valid the cycle after the address
out_valid  out  1  decoded packet valid
out_ready  in  1  execute accepts the packet
opcode  out  3  instr[15:13]
aluop  out  2  instr[12:11]
shift  out  2  instr[4:3] for opcode 110 or 101, else 0
wr_num  out  3  destination register
wr_en  out  1  instruction writes a register
op_a  out  DATA_W  operand A (0 if unused)
op_b  out  DATA_W  operand B (0 if unused)
sximm5  out  DATA_W  instr[4:0] sign-extended
sximm8  out  DATA_W  instr[7:0] sign-extended
halt  out  1  opcode 111
illegal  out  1  unsupported opcode/op combination

Behaviour:
- Fields: Rn = instr[10:8], Rd = instr[7:5], Rm = instr[2:0].
- Decode table (need A / need B / wr_num / wr_en):
  - MOV imm 110/10: –/– /Rn/1.
  - MOV reg 110/00: –/Rm/Rd/1.
  - ADD 101/00 and AND 101/10: Rn/Rm/Rd/1.
  - CMP 101/01: Rn/Rm/–/0.
  - MVN 101/11: –/Rm/Rd/1.
  - LDR 011/00: Rn/–/Rd/1.
  - STR 100/00: Rn/Rd/–/0.
  - HALT 111/any: no reads, halt=1, wr_en=0.
  - Anything else: illegal=1, no reads, wr_en=0.
- FSM states: IDLE, REQ_A, REQ_B, REQ_AB, DRAIN, OUT.
- IDLE: in_ready=1. On accept, latch instr and go to:
  - OUT if no operand is needed;
  - REQ_AB if READ_PORTS=2 and any operand is needed;
  - otherwise REQ_A (A needed) or REQ_B (only B needed).
- REQ_A drives rf_addr_a = the A register; next state is REQ_B if B is needed, else DRAIN.
- REQ_B (single port) drives rf_addr_a = the B register and captures rf_data_a into op_a at its closing edge if a request is outstanding; next state DRAIN.
- REQ_AB drives both addresses; next state DRAIN.
- DRAIN captures the outstanding data into op_a/op_b; next state OUT.
- Latency from the accept edge N to out_valid: no operands N+1; one operand, or two with READ_PORTS=2, N+3; two operands with READ_PORTS=1, N+4.
- OUT: out_valid=1. All packet outputs hold stable while out_ready=0.
  - On out_ready with in_valid, accept the next instruction in the same cycle (in_ready = OUT & out_ready) and branch as from IDLE.
  - On out_ready with no in_valid, go to IDLE.
- in_ready=0 in REQ_*, DRAIN, and OUT without out_ready.
- Unused rf addresses are driven 0. Unused op_a/op_b are 0.
- Reset (any state, including mid-fetch): state=IDLE; out_valid, all packet outputs, and rf addresses = 0. in_ready is forced 0 while reset is high. Any in-flight instruction is discarded.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (OP_MOV=110, OP_ALU=101, OP_LDR=011, OP_STR=100, OP_HALT=111);
  - the state enum;
  - a packed decoded-fields struct {need_a, need_b, src_a, src_b, wr_num, wr_en, halt, illegal}.
- Sub-module instr_fields: purely combinational; maps instr[15:0] to the struct plus shift, sximm5 and sximm8 at DATA_W. The FSM and operand registers live in decode_stage.

Test Plan:
- READ_PORTS=1: ADD R2,R1,R0 LSL#1 (0xA148), rf R1=7, R0=9 -> addr_a=1 then 0; out_valid at N+4; op_a=7, op_b=9, wr_num=2, wr_en=1, shift=01.
- MOV R3,#-5 (0xD3FB) -> out_valid at N+1, no rf addresses driven, sximm8=0xFFFB, wr_num=3, op_a=op_b=0.
- READ_PORTS=2: STR R5,[R4,#3] (0x84A3), R4=0x10, R5=0x22 -> addr_a=4 and addr_b=5 in the same cycle; out_valid at N+3; op_a=0x10, op_b=0x22, sximm5=3, wr_en=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> packet stable, in_ready=0. Release -> next instruction accepted in the same cycle.
- HALT 0xE000 -> halt=1. Word 0x0000 -> illegal=1. Neither issues a read.
- Reset asserted in REQ_B -> next cycle IDLE, out_valid=0, op_a=0, the prior instruction is never emitted.
